// File: rtl/fft_input_loader.sv
// fft_input_loader: collects 8 complex samples in bit-reversed slot order and presents them as one parallel frame.
// An early start-of-frame marker drops the partial frame and raises a one-cycle sync_err.
module fft_input_loader #(
    parameter int N = 3,
    localparam int W = 2**N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   in_r,
    input  logic [W-1:0]   in_i,
    input  logic           in_valid,
    input  logic           in_sof,
    output logic           in_ready,
    output logic [8*W-1:0] out_r,
    output logic [8*W-1:0] out_i,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sync_err
);
    typedef enum logic {FILL, FULL} state_t;
    state_t         state_q, state_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [8*W-1:0] r_q, r_d, i_q, i_d;
    logic           err_q, err_d;
    logic           acc;
    logic [2:0]     idx, slot;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
            r_q     <= '0;
            i_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            i_q     <= i_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        i_d     = i_q;
        err_d   = 1'b0;
        acc     = in_valid && state_q == FILL;
        // a marker always restarts the frame at index 0, whatever was collected so far
        idx     = in_sof ? 3'd0 : cnt_q;
        slot    = {idx[0], idx[1], idx[2]};
        if (acc) begin
            for (int j = 0; j < 8; j++)
                if (slot == 3'(j)) begin
                    r_d[j*W +: W] = in_r;
                    i_d[j*W +: W] = in_i;
                end
            err_d = in_sof && cnt_q != 3'd0;
            cnt_d = idx + 3'd1;
            state_d = idx == 3'd7 ? FULL : FILL;
        end else if (state_q == FULL && out_ready) begin
            state_d = FILL;
        end
    end
    assign in_ready  = state_q == FILL;
    assign out_valid = state_q == FULL;
    assign out_r     = r_q;
    assign out_i     = i_q;
    assign sync_err  = err_q;
endmodule

// File: tb/tb_fft_input_loader.sv
// tb_fft_input_loader: table-driven checks plus a cycle model whose completed frames are queued and
// compared against each frame the loader presents.
module tb_fft_input_loader;
    localparam int N = 3;
    localparam int W = 8;

    logic           clk, rst;
    logic [W-1:0]   in_r, in_i;
    logic           in_valid, in_sof, in_ready;
    logic [8*W-1:0] out_r, out_i;
    logic           out_valid, out_ready, sync_err;

    fft_input_loader #(.N(N)) dut (
        .clk(clk), .rst(rst), .in_r(in_r), .in_i(in_i), .in_valid(in_valid),
        .in_sof(in_sof), .in_ready(in_ready), .out_r(out_r), .out_i(out_i),
        .out_valid(out_valid), .out_ready(out_ready), .sync_err(sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           k;
        int           slot;
        logic [W-1:0] r;
        logic [W-1:0] i;
    } vec_t;
    vec_t tbl [8];

    typedef struct {
        logic [8*W-1:0] r;
        logic [8*W-1:0] i;
    } frame_t;
    frame_t q [$];

    int passed = 0;
    int total  = 0;

    task automatic chk(input string nm, input logic [8*W-1:0] act, input logic [8*W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [2:0] rev_lut(input logic [2:0] k);
        case (k)
            3'd1: rev_lut = 3'd4;
            3'd3: rev_lut = 3'd6;
            3'd4: rev_lut = 3'd1;
            3'd6: rev_lut = 3'd3;
            default: rev_lut = k;
        endcase
    endfunction

    // reference model, independent of the DUT
    logic           m_full, m_err;
    logic [2:0]     m_cnt;
    logic [8*W-1:0] m_rv, m_iv;
    logic [2:0]     m_slot;
    assign m_slot = rev_lut(in_sof ? 3'd0 : m_cnt);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_full <= 1'b0;
            m_err  <= 1'b0;
            m_cnt  <= 3'd0;
            m_rv   <= '0;
            m_iv   <= '0;
        end else begin
            m_err <= 1'b0;
            if (!m_full && in_valid) begin
                m_rv[m_slot*W +: W] <= in_r;
                m_iv[m_slot*W +: W] <= in_i;
                m_err <= in_sof && (m_cnt != 3'd0);
                m_cnt <= in_sof ? 3'd1 : m_cnt + 3'd1;
                if (!in_sof && m_cnt == 3'd7) m_full <= 1'b1;
            end else if (m_full && out_ready) begin
                m_full <= 1'b0;
            end
        end
    end

    initial begin
        logic m_full_prev = 1'b0;
        logic ov_prev = 1'b0;
        frame_t f;
        forever begin
            @(negedge clk);
            if (m_full && !m_full_prev) q.push_back('{m_rv, m_iv});
            chk("in_ready", in_ready, !m_full);
            chk("out_valid", out_valid, m_full);
            chk("sync_err", sync_err, m_err);
            if (out_valid && !ov_prev) begin
                chk("frame_queued", q.size() != 0, 1);
                if (q.size() != 0) begin
                    f = q.pop_front();
                    chk("frame_r", out_r, f.r);
                    chk("frame_i", out_i, f.i);
                end
            end
            m_full_prev = m_full;
            ov_prev = out_valid;
        end
    end

    task automatic step(input logic v, input logic [W-1:0] r, input logic [W-1:0] i, input logic s);
        in_valid = v;
        in_r = r;
        in_i = i;
        in_sof = s;
        @(posedge clk);
        #1;
    endtask

    task automatic check_table(input string nm);
        for (int k = 0; k < 8; k++) begin
            chk({nm, "_slot_r"}, out_r[tbl[k].slot*W +: W], tbl[k].r);
            chk({nm, "_slot_i"}, out_i[tbl[k].slot*W +: W], tbl[k].i);
        end
    endtask

    initial begin
        int nv, ne;
        int pos [3];
        tbl[0] = '{0, 0, 8'd1,   8'd0};
        tbl[1] = '{1, 4, 8'd17,  8'd1};
        tbl[2] = '{2, 2, 8'd33,  8'd2};
        tbl[3] = '{3, 6, 8'd49,  8'd3};
        tbl[4] = '{4, 1, 8'd65,  8'd4};
        tbl[5] = '{5, 5, 8'd81,  8'd5};
        tbl[6] = '{6, 3, 8'd97,  8'd6};
        tbl[7] = '{7, 7, 8'd113, 8'd7};
        rst = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_r = '0;
        in_i = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sync_err", sync_err, 0);
        chk("rst_out_r", out_r, 0);
        chk("rst_out_i", out_i, 0);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) step(1, W'(100 + k), W'(200 + k), 0);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_r", out_r, 0);
        chk("midrst_out_i", out_i, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int k = 0; k < 8; k++) step(1, tbl[k].r, tbl[k].i, 0);
        chk("order_out_valid", out_valid, 1);
        check_table("order");

        for (int c = 0; c < 20; c++) begin
            step(1, 8'hEE, 8'h11, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        check_table("bp_hold");
        out_ready = 1'b1;
        step(1, 8'hEE, 8'h11, 0);
        out_ready = 1'b0;
        chk("bp_release_in_ready", in_ready, 1);
        chk("bp_release_out_valid", out_valid, 0);

        for (int k = 0; k < 8; k++) begin
            step(1, tbl[k].r, tbl[k].i, 0);
            if (k < 7) begin
                chk("gap_out_valid", out_valid, 0);
                step(0, 8'h00, 8'h00, 0);
                step(0, 8'h00, 8'h00, 0);
            end
        end
        chk("gap_out_valid_end", out_valid, 1);
        check_table("gap");
        out_ready = 1'b1;
        step(0, 8'h00, 8'h00, 0);
        out_ready = 1'b0;

        step(1, 8'h01, 8'h02, 0);
        step(1, 8'h03, 8'h04, 0);
        step(1, 8'h05, 8'h06, 1);
        chk("dbl_err1", sync_err, 1);
        step(1, 8'h07, 8'h08, 1);
        chk("dbl_err2", sync_err, 1);
        step(0, 8'h00, 8'h00, 0);
        chk("dbl_err_end", sync_err, 0);

        for (int k = 0; k < 3; k++) step(1, W'(8'h10 + k), W'(8'h20 + k), 0);
        step(1, 8'h55, 8'hAA, 1);
        chk("resync_err", sync_err, 1);
        for (int k = 1; k < 8; k++) begin
            step(1, W'(8'h30 + k), W'(8'h40 + k), 0);
            if (k == 1) chk("resync_err_once", sync_err, 0);
            if (k < 7) chk("resync_not_full", out_valid, 0);
        end
        chk("resync_full", out_valid, 1);
        chk("resync_slot0_r", out_r[7:0], 8'h55);
        chk("resync_slot0_i", out_i[7:0], 8'hAA);
        chk("resync_slot4_r", out_r[4*W +: W], 8'h31);
        out_ready = 1'b1;
        step(0, 8'h00, 8'h00, 0);

        nv = 0;
        ne = 0;
        for (int c = 0; c < 28; c++) begin
            step(c < 26, W'(c * 7 + 3), W'(c ^ 8'h5A), 0);
            if (out_valid === 1'b1) begin
                if (nv < 3) pos[nv] = c;
                nv++;
            end
            if (sync_err !== 1'b0) ne++;
        end
        chk("b2b_frames", nv, 3);
        chk("b2b_pos0", pos[0], 7);
        chk("b2b_pos1", pos[1], 16);
        chk("b2b_pos2", pos[2], 25);
        chk("b2b_sync_err", ne, 0);
        chk("b2b_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/fft_input_loader.md
# fft_input_loader

Serial-to-parallel input stage of the 8-point FFT datapath, directly upstream of the first butterfly stage. Accepts one complex sample per handshake, stores each sample in bit-reversed slot order, and presents a complete 8-sample frame in parallel so each adjacent slot pair feeds one first-stage butterfly. Frame alignment comes from a start-of-frame marker, with misalignment detection and recovery.

## Interface
- N, default 3: log2 of sample component width; each real/imaginary component is W = 2**N bits (8 at default).
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- in_r, in_i  input  W each  real/imaginary part of incoming sample.
- in_valid  input  1  sample present on in_r/in_i.
- in_sof  input  1  marks accepted sample as time index 0 of a new frame; qualified by in_valid.
- in_ready  output  1  loader can accept a sample this cycle.
- out_r, out_i  output  8*W each  frame in bit-reversed order; slot j occupies bits [j*W +: W].
- out_valid  output  1  complete frame presented.
- out_ready  input  1  downstream consumes frame this cycle.
- sync_err  output  1  one-cycle pulse: partial frame discarded due to early in_sof.

## Operation
- Accept condition: in_valid && in_ready on a rising edge.
- Two states: FILL (in_ready=1, out_valid=0) and FULL (in_ready=0, out_valid=1). in_ready and out_valid decode from the state register only, never from inputs.
- 3-bit sample counter cnt holds next time index; an accepted sample with index k is written to slot rev(k): 0→0, 1→4, 2→2, 3→6, 4→1, 5→5, 6→3, 7→7.
- FILL, accept, in_sof=0: write slot rev(cnt), cnt+1. On cnt==7: write slot 7, cnt→0, state→FULL.
- FILL, accept, in_sof=1, cnt==0: normal write to slot 0, cnt→1.
- FILL, accept, in_sof=1, cnt!=0: partial frame discarded; sample written to slot 0, cnt→1; sync_err=1 next cycle. Stale slots are overwritten as refilling proceeds; no clearing.
- FILL, accept with in_sof=0 while cnt==0: accepted as index 0 (no marker required for the first frame or back-to-back frames).
- FULL: input ignored (in_ready=0). out_valid && out_ready → state FILL, cnt stays 0.
- Out buses are the slot registers directly; stable and unchanged throughout FULL.
- No arithmetic on data; samples are stored bit-exact, no width change.
- Reset (asserted any time, including mid-frame or in FULL): state FILL, cnt 0, all slots 0, sync_err 0, partial or pending frame lost.

## Timing
- Reset values: in_ready=1, out_valid=0, sync_err=0, out_r=out_i=0.
- Latency: 8th sample accepted at edge t → out_valid=1 from t (visible in cycle after edge t), out data valid same cycle.
- Consume at edge u (out_valid && out_ready) → in_ready=1 after u; next sample accepted no earlier than edge u+1. Minimum frame period 9 cycles with continuous input and out_ready held 1.
- out_ready may be held high indefinitely; asserting it in FILL has no effect.
- sync_err high exactly one cycle after the offending accept edge; two consecutive offending accepts produce two consecutive pulses.
- in_valid gaps in FILL hold cnt and slots unchanged.
- Async reset assertion clears state immediately; deassertion is synchronised externally.

## Test plan
- Reset: assert rst=0 mid-fill of 5 samples, release → in_ready=1, out_valid=0, outputs 0; next 8 samples form a clean frame.
- Ordering: feed in_r=k*16+1, in_i=k for k=0..7 continuous → out_valid after 8th accept; slot j holds sample rev(j), e.g. slot 1 = (65,4), slot 3 = (97,6), slot 6 = (49,3).
- Backpressure: complete frame, hold out_ready=0 for 20 cycles with in_valid=1 → in_ready=0, no samples taken, out buses unchanged; out_ready=1 one cycle → in_ready=1 next cycle, cnt=0.
- Gaps: 8 samples with in_valid toggling 1,0,0,1,... → identical frame contents to continuous case, out_valid only after 8th accept.
- Resync: 3 samples, then sample (0x55,0xAA) with in_sof=1 → sync_err pulse one cycle, 7 more samples complete a frame with slot 0 = (0x55,0xAA), out_valid after those 7.
- Back-to-back: out_ready tied 1, 24 continuous samples → three frames, each out_valid for exactly one cycle, frame period 9 cycles, no sync_err.
